// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: gshare direction PHT plus direct-mapped BTB.
// Optional feature macro: GSHARE_EN. When defined, PHT indices are XORed
// with the global history; when undefined the predictor runs in bimodal mode
// (PC-only indexing) and the GHR is still maintained and exported.
`timescale 1ns/1ps
module branch_predictor #(
    parameter int GHR_BITS = 8,
    parameter int BTB_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         fetch_pc,
    output logic                pred_taken,
    output logic [31:0]         pred_target,
    output logic                btb_hit,
    input  logic                upd_en,
    input  logic [31:0]         upd_pc,
    input  logic                upd_taken,
    input  logic [31:0]         upd_target,
    input  logic [GHR_BITS-1:0] upd_ghr,
    output logic [GHR_BITS-1:0] ghr
);

    localparam int PHT_N = 2 ** GHR_BITS;
    localparam int BTB_N = 2 ** BTB_BITS;
    localparam int TAG_W = 30 - BTB_BITS;

    logic [1:0]          pht_q     [PHT_N];
    logic [1:0]          pht_d     [PHT_N];
    logic                btb_vld_q [BTB_N];
    logic                btb_vld_d [BTB_N];
    logic [TAG_W-1:0]    btb_tag_q [BTB_N];
    logic [TAG_W-1:0]    btb_tag_d [BTB_N];
    logic [31:0]         btb_tgt_q [BTB_N];
    logic [31:0]         btb_tgt_d [BTB_N];
    logic [GHR_BITS-1:0] ghr_q;
    logic [GHR_BITS-1:0] ghr_d;

    logic [GHR_BITS-1:0] pred_idx;
    logic [GHR_BITS-1:0] upd_idx;
    logic [BTB_BITS-1:0] fetch_bidx;
    logic [BTB_BITS-1:0] upd_bidx;
    logic [TAG_W-1:0]    fetch_tag;
    logic [TAG_W-1:0]    upd_tag;

    // The two low PC bits never matter for word-aligned instructions, and
    // the carried history is only consumed in gshare mode.
    logic unused_bits;
    assign unused_bits = ^{upd_pc[1:0], upd_ghr};

    assign ghr = ghr_q;

    // Table indices and BTB tags for the fetch (read) and resolve (write) ports.
    always_comb begin
`ifdef GSHARE_EN
        pred_idx = fetch_pc[GHR_BITS+1:2] ^ ghr_q;
        upd_idx  = upd_pc[GHR_BITS+1:2] ^ upd_ghr;
`else
        pred_idx = fetch_pc[GHR_BITS+1:2];
        upd_idx  = upd_pc[GHR_BITS+1:2];
`endif
        fetch_bidx = fetch_pc[BTB_BITS+1:2];
        upd_bidx   = upd_pc[BTB_BITS+1:2];
        fetch_tag  = fetch_pc[31:BTB_BITS+2];
        upd_tag    = upd_pc[31:BTB_BITS+2];
    end

    // Zero-latency prediction from registered state only (no write-through).
    always_comb begin
        btb_hit     = btb_vld_q[fetch_bidx] && (btb_tag_q[fetch_bidx] == fetch_tag);
        pred_taken  = btb_hit && pht_q[pred_idx][1];
        pred_target = pred_taken ? btb_tgt_q[fetch_bidx] : fetch_pc + 32'd4;
    end

    // Training: saturating PHT counter, BTB fill on taken, non-speculative GHR shift.
    always_comb begin
        pht_d     = pht_q;
        btb_vld_d = btb_vld_q;
        btb_tag_d = btb_tag_q;
        btb_tgt_d = btb_tgt_q;
        ghr_d     = ghr_q;
        if (upd_en) begin
            if (upd_taken) begin
                if (pht_q[upd_idx] != 2'b11) begin
                    pht_d[upd_idx] = pht_q[upd_idx] + 2'd1;
                end
                btb_vld_d[upd_bidx] = 1'b1;
                btb_tag_d[upd_bidx] = upd_tag;
                btb_tgt_d[upd_bidx] = upd_target;
            end else if (pht_q[upd_idx] != 2'b00) begin
                pht_d[upd_idx] = pht_q[upd_idx] - 2'd1;
            end
            ghr_d = {ghr_q[GHR_BITS-2:0], upd_taken};
        end
    end

    // State registers; reset returns every counter to weak not-taken and
    // empties the BTB, overriding any update presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht_q[i] <= 2'b01;
            end
            for (int i = 0; i < BTB_N; i++) begin
                btb_vld_q[i] <= 1'b0;
                btb_tag_q[i] <= '0;
                btb_tgt_q[i] <= '0;
            end
            ghr_q <= '0;
        end else begin
            pht_q     <= pht_d;
            btb_vld_q <= btb_vld_d;
            btb_tag_q <= btb_tag_d;
            btb_tgt_q <= btb_tgt_d;
            ghr_q     <= ghr_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (GHR_BITS=8, BTB_BITS=4).
// Expected values come from a table-level model of the predictor.
`timescale 1ns/1ps
module tb_branch_predictor;

`ifdef GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        btb_hit;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [7:0]  upd_ghr;
    logic [7:0]  ghr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_pht  [256];
    bit          m_bv   [16];
    logic [31:0] m_bpc  [16];
    logic [31:0] m_btgt [16];
    int          m_ghr;

    always #5 clk = ~clk;

    branch_predictor #(.GHR_BITS(8), .BTB_BITS(4)) dut (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .btb_hit(btb_hit),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_ghr(upd_ghr), .ghr(ghr)
    );

    function automatic int m_idx(logic [31:0] pc, int g);
        int w;
        w = int'((pc >> 2) & 32'hFF);
        return GSHARE ? ((w ^ g) & 255) : w;
    endfunction

    function automatic int m_bi(logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        logic [31:0] stored;
        stored = m_bpc[m_bi(pc)];
        return m_bv[m_bi(pc)] && ((stored >> 6) == (pc >> 6));
    endfunction

    function automatic bit m_taken(logic [31:0] pc);
        return m_hit(pc) && (m_pht[m_idx(pc, m_ghr)] >= 2);
    endfunction

    function automatic logic [31:0] m_target(logic [31:0] pc);
        return m_taken(pc) ? m_btgt[m_bi(pc)] : pc + 32'd4;
    endfunction

    // Advance one clock; the model absorbs whatever the inputs held at the edge.
    task automatic tick();
        int i;
        @(posedge clk);
        if (!reset) begin
            for (int k = 0; k < 256; k++) m_pht[k] = 1;
            for (int k = 0; k < 16; k++) begin
                m_bv[k] = 1'b0; m_bpc[k] = '0; m_btgt[k] = '0;
            end
            m_ghr = 0;
        end else if (upd_en) begin
            i = m_idx(upd_pc, int'(upd_ghr));
            if (upd_taken) begin
                m_pht[i] = (m_pht[i] == 3) ? 3 : m_pht[i] + 1;
                m_bv[m_bi(upd_pc)]   = 1'b1;
                m_bpc[m_bi(upd_pc)]  = upd_pc;
                m_btgt[m_bi(upd_pc)] = upd_target;
            end else begin
                m_pht[i] = (m_pht[i] == 0) ? 0 : m_pht[i] - 1;
            end
            m_ghr = (m_ghr * 2 + (upd_taken ? 1 : 0)) % 256;
        end
        #1;
    endtask

    task automatic set_upd(bit en, logic [31:0] pc, bit tk, logic [31:0] tgt, logic [7:0] g);
        upd_en = en; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_ghr = g;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_upd(0, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_upd(1, 32'h40, 1, 32'h100, 8'h00);   // must be ignored
        fetch_pc = 32'h40;
        tick();
        tick();
        reset = 1'b1;
        set_upd(0, 0, 0, 0, 0);
        fetch_pc = 32'h40;
        #1;
        n_checks++; if (btb_hit !== 1'b0) begin n_fail++; $display("FAIL reset_btb_hit: got %0b want 0", btb_hit); end
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken: got %0b want 0", pred_taken); end
        n_checks++; if (pred_target !== 32'h44) begin n_fail++; $display("FAIL reset_pred_target: got %h want 00000044", pred_target); end
        n_checks++; if (ghr !== 8'h00) begin n_fail++; $display("FAIL reset_ghr: got %h want 00", ghr); end
        fetch_pc = 32'hFFFF_FFFC;
        #1;
        n_checks++; if (pred_target !== 32'h0) begin n_fail++; $display("FAIL wrap_target: got %h want 00000000", pred_target); end
    endtask

    task automatic test_train_taken();
        set_upd(1, 32'h40, 1, 32'h100, 8'h00);
        fetch_pc = 32'h40;
        tick();
        set_upd(0, 0, 0, 0, 0);
        #1;
        n_checks++; if (ghr !== 8'h01) begin n_fail++; $display("FAIL train_ghr: got %h want 01", ghr); end
        n_checks++; if (btb_hit !== 1'b1) begin n_fail++; $display("FAIL train_btb_hit: got %0b want 1", btb_hit); end
        n_checks++; if (pred_taken !== !GSHARE) begin n_fail++; $display("FAIL train_pred_taken: got %0b want %0b", pred_taken, !GSHARE); end
        n_checks++; if (pred_target !== (GSHARE ? 32'h44 : 32'h100)) begin n_fail++; $display("FAIL train_pred_target: got %h want %h", pred_target, GSHARE ? 32'h44 : 32'h100); end
    endtask

    task automatic test_saturation();
        do_reset();
        // Seed a BTB entry whose gshare index later lands on the trained counter.
        set_upd(1, 32'h1B8, 1, 32'h300, 8'h00);
        tick();
        for (int k = 0; k < 6; k++) begin
            set_upd(1, 32'h40, (k < 5), 32'h100, 8'h00);
            tick();
            set_upd(0, 0, 0, 0, 0);
            fetch_pc = 32'h40;
            #1;
            n_checks++; if (pred_taken !== m_taken(fetch_pc)) begin n_fail++; $display("FAIL sat_pred_taken[%0d]: got %0b want %0b", k, pred_taken, m_taken(fetch_pc)); end
            n_checks++; if (pred_target !== m_target(fetch_pc)) begin n_fail++; $display("FAIL sat_pred_target[%0d]: got %h want %h", k, pred_target, m_target(fetch_pc)); end
        end
        n_checks++; if (ghr !== 8'h7E) begin n_fail++; $display("FAIL sat_ghr: got %h want 7e", ghr); end
        fetch_pc = 32'h1B8;
        #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL sat_stays_taken: got %0b want 1", pred_taken); end
        n_checks++; if (pred_target !== 32'h300) begin n_fail++; $display("FAIL sat_target: got %h want 00000300", pred_target); end
    endtask

    task automatic test_alias();
        do_reset();
        set_upd(1, 32'h40, 1, 32'h100, 8'h00);
        tick();
        set_upd(1, 32'h80, 1, 32'h200, 8'h00);
        tick();
        set_upd(0, 0, 0, 0, 0);
        fetch_pc = 32'h40;
        #1;
        n_checks++; if (btb_hit !== 1'b0) begin n_fail++; $display("FAIL alias_old_hit: got %0b want 0", btb_hit); end
        n_checks++; if (pred_target !== 32'h44) begin n_fail++; $display("FAIL alias_old_target: got %h want 00000044", pred_target); end
        fetch_pc = 32'h80;
        #1;
        n_checks++; if (btb_hit !== 1'b1) begin n_fail++; $display("FAIL alias_new_hit: got %0b want 1", btb_hit); end
        n_checks++; if (pred_target !== m_target(fetch_pc)) begin n_fail++; $display("FAIL alias_new_target: got %h want %h", pred_target, m_target(fetch_pc)); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        fetch_pc = 32'h40;
        set_upd(1, 32'h40, 1, 32'h100, 8'h00);
        #1;
        n_checks++; if (btb_hit !== 1'b0) begin n_fail++; $display("FAIL same_cycle_hit: got %0b want 0", btb_hit); end
        n_checks++; if (pred_target !== 32'h44) begin n_fail++; $display("FAIL same_cycle_target: got %h want 00000044", pred_target); end
        tick();
        set_upd(0, 0, 0, 0, 0);
        #1;
        n_checks++; if (btb_hit !== 1'b1) begin n_fail++; $display("FAIL next_cycle_hit: got %0b want 1", btb_hit); end
    endtask

    task automatic test_ghr_reset();
        logic [31:0] pcs [9];
        do_reset();
        for (int k = 0; k < 9; k++) begin
            pcs[k] = (k < 6) ? ($urandom_range(0, 255) << 2) : 32'h40;
            set_upd(1, pcs[k], 1, $urandom & 32'hFFFF_FFFC,
                    (k < 6) ? 8'($urandom_range(0, 255)) : 8'h02);
            tick();
        end
        set_upd(0, 0, 0, 0, 0);
        #1;
        n_checks++; if (ghr !== 8'hFF) begin n_fail++; $display("FAIL ghr_shift: got %h want ff", ghr); end
        reset = 1'b0;
        set_upd(1, 32'h40, 1, 32'h500, 8'h02);
        tick();
        reset = 1'b1;
        set_upd(0, 0, 0, 0, 0);
        #1;
        n_checks++; if (ghr !== 8'h00) begin n_fail++; $display("FAIL midreset_ghr: got %h want 00", ghr); end
        for (int k = 0; k < 9; k++) begin
            fetch_pc = pcs[k];
            #1;
            n_checks++; if (btb_hit !== 1'b0) begin n_fail++; $display("FAIL midreset_hit[%0d]: got %0b want 0", k, btb_hit); end
        end
        // From 01, one taken then one not-taken returns to not-taken.
        set_upd(1, 32'h40, 1, 32'h100, 8'h02);
        tick();
        set_upd(1, 32'h40, 0, 32'h0, 8'h02);
        tick();
        set_upd(0, 0, 0, 0, 0);
        fetch_pc = 32'h40;
        #1;
        n_checks++; if (btb_hit !== 1'b1) begin n_fail++; $display("FAIL midreset_retrain_hit: got %0b want 1", btb_hit); end
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL midreset_pht: got %0b want 0", pred_taken); end
    endtask

    task automatic test_random();
        logic [31:0] pool [12];
        for (int k = 0; k < 12; k++) begin
            pool[k] = (k < 8) ? ($urandom_range(0, 63) << 2) : ($urandom & 32'hFFFF_FFFC);
        end
        pool[11] = 32'hFFFF_FFFC;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 79) != 0);
            fetch_pc = pool[$urandom_range(0, 11)];
            set_upd(($urandom_range(0, 9) < 6), pool[$urandom_range(0, 11)],
                    $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC,
                    ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(m_ghr));
            #1;
            n_checks++; if (btb_hit !== m_hit(fetch_pc)) begin n_fail++; $display("FAIL rnd_hit[%0d]: pc %h got %0b want %0b", c, fetch_pc, btb_hit, m_hit(fetch_pc)); end
            n_checks++; if (pred_taken !== m_taken(fetch_pc)) begin n_fail++; $display("FAIL rnd_taken[%0d]: pc %h got %0b want %0b", c, fetch_pc, pred_taken, m_taken(fetch_pc)); end
            n_checks++; if (pred_target !== m_target(fetch_pc)) begin n_fail++; $display("FAIL rnd_target[%0d]: pc %h got %h want %h", c, fetch_pc, pred_target, m_target(fetch_pc)); end
            n_checks++; if (ghr !== 8'(m_ghr)) begin n_fail++; $display("FAIL rnd_ghr[%0d]: got %h want %h", c, ghr, 8'(m_ghr)); end
            tick();
        end
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        fetch_pc = '0;
        set_upd(0, 0, 0, 0, 0);
        test_reset();
        test_train_taken();
        test_saturation();
        test_alias();
        test_same_cycle();
        test_ghr_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Gshare direction predictor plus direct-mapped branch target buffer (BTB) for the pipelined CPU's fetch stage. It sits directly upstream of the PC register. Each cycle it takes the current fetch PC and returns a taken/not-taken prediction and a target; the fetch mux uses these to choose the next PC. Execute-stage branch resolution feeds back into it to train the pattern history table (PHT), the BTB and the global history register (GHR).

## Interface
Parameters:
- `GHR_BITS`, default 8: history length; the PHT has 2^GHR_BITS entries.
- `BTB_BITS`, default 4: BTB index width; the BTB has 2^BTB_BITS entries.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `fetch_pc`  in  32  PC of the instruction being fetched.
- `pred_taken`  out  1  predicted taken; only asserted when the BTB also hits.
- `pred_target`  out  32  predicted target; equals `fetch_pc+4` when `pred_taken`=0.
- `btb_hit`  out  1  BTB entry is valid and its tag matches `fetch_pc`.
- `upd_en`  in  1  a conditional branch resolved in EX this cycle.
- `upd_pc`  in  32  PC of the resolved branch.
- `upd_taken`  in  1  actual direction.
- `upd_target`  in  32  actual taken target.
- `upd_ghr`  in  GHR_BITS  GHR value carried down the pipe with the branch (the value used at its prediction).
- `ghr`  out  GHR_BITS  current global history, exported for debug and for the pipeline to carry.

## Operation
- PHT: 2^GHR_BITS two-bit saturating counters. Encoding: 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken. Counter bit 1 gives the direction.
- Predict index = `fetch_pc[GHR_BITS+1:2] ^ ghr`.
- Update index = `upd_pc[GHR_BITS+1:2] ^ upd_ghr`.
- BTB entry fields: valid, tag = `pc[31:BTB_BITS+2]`, target[31:0]. BTB index = `pc[BTB_BITS+1:2]`.
- Prediction logic is combinational from registered state: `pred_taken = btb_hit & pht[idx][1]`, and `pred_target = pred_taken ? btb_target : fetch_pc+4`. The +4 is modulo 2^32 (0xFFFFFFFC wraps to 0).
- On `upd_en`=1:
  - PHT counter at the update index increments if `upd_taken`, otherwise decrements. It saturates at 11 and 00.
  - If `upd_taken`, the BTB entry at the update index is written: valid=1, tag, `upd_target`. This replaces any existing entry, whatever its tag.
  - If not taken, the BTB is unchanged.
- GHR is updated non-speculatively and only on `upd_en`: `ghr <= {ghr[GHR_BITS-2:0], upd_taken}`. The oldest bit drops out.
- When `upd_en`=0, no state changes.

## Timing
- Prediction latency is 0 cycles: outputs follow `fetch_pc` combinationally.
- Update latency is 1 cycle: new PHT, BTB and GHR values are visible to predictions in the cycle after the `upd_en` edge.
- Simultaneous predict and update on the same PHT or BTB entry: the prediction uses the old value. There is no write-through bypass.
- Reset (`reset`=0 at a rising edge):
  - All PHT counters go to 01.
  - All BTB valid bits clear. Tags and targets go to 0.
  - `ghr` goes to 0.
  - Any `upd_en` in that cycle is ignored.
- Outputs right after reset: `btb_hit`=0, `pred_taken`=0, `pred_target=fetch_pc+4`, `ghr`=0.
- Reset asserted mid-run takes effect at the next edge and discards all training.

## Configuration
- `GSHARE_EN` defined (default build): PHT indices use the XOR with the GHR as described above.
- `GSHARE_EN` undefined: bimodal mode.
  - Predict index = `fetch_pc[GHR_BITS+1:2]`.
  - Update index = `upd_pc[GHR_BITS+1:2]`.
  - `upd_ghr` is ignored.
  - The GHR is still maintained and exported, so that port behaviour is identical in both builds.

## Test plan
- **Post-reset default:** hold `reset`=0 for 2 cycles, release, drive `fetch_pc`=0x00000040 → `btb_hit`=0, `pred_taken`=0, `pred_target`=0x00000044, `ghr`=0x00.
- **Train taken:** one update with `upd_pc`=0x40, `upd_taken`=1, `upd_target`=0x100, `upd_ghr`=0. Next cycle, drive `fetch_pc`=0x40 with `ghr`=0x01. Required result: PHT index 0x11 is still 01, so `pred_taken`=0 while `btb_hit`=1. In bimodal mode (index 0x10 → 10), `pred_taken`=1 and `pred_target`=0x100.
- **Saturation:** 5 taken updates to the same PC with `upd_ghr`=0, then 1 not-taken → counter follows 01→10→11→11→11→11→10, and a prediction at that index stays taken.
- **BTB alias replacement:** taken update at 0x40 (target 0x100), then taken update at 0x80 (same index for BTB_BITS=4, different tag; target 0x200). Then `fetch_pc`=0x40 → `btb_hit`=0.
- **Same-cycle read/write:** drive `fetch_pc`=0x40 and a taken update of 0x40 in the same cycle → that cycle shows the old `btb_hit`=0; the next cycle shows `btb_hit`=1.
- **GHR shift and mid-run reset:** 9 taken updates → `ghr`=0xFF. Then assert `reset` for one edge while `upd_en`=1 → `ghr`=0x00, all BTB entries miss, PHT back to 01.
